carregador_programa: RTL and testbench
======================================

# carregador_programa

Boot loader for the 8-bit nRISC processor. It receives a program as a byte stream over a valid/ready handshake and writes it into the instruction memory's load port. It holds the processor in reset until a complete, checksum-verified image is in memory, then releases it. It sits directly upstream of the processor core and instruction memory.

## Interface
- `TIMEOUT`, default 1000: number of consecutive idle cycles allowed inside a transfer before aborting; must be ≥ 2.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all internal state immediately.
- `byte_in`  in  8  incoming stream byte.
- `byte_valid`  in  1  `byte_in` is valid this cycle.
- `byte_ready`  out  1  loader accepts a byte this cycle. A transfer occurs when `byte_valid` and `byte_ready` are both 1 at a rising edge.
- `mem_addr`  out  8  instruction memory write address.
- `mem_dado`  out  8  instruction memory write data.
- `mem_esc`  out  1  instruction memory write enable, one-cycle pulse.
- `cpu_reset`  out  1  reset to the processor; 1 while loading, 0 after a successful load.
- `carregado`  out  1  a valid image has been loaded.
- `erro_checksum`  out  1  abort: checksum mismatch or zero length.
- `erro_timeout`  out  1  abort: idle timeout.

## Operation
- **Stream format:** length byte N (1..255), then N program bytes, then one checksum byte. Program bytes go to addresses 0..N-1 in order.
- **Checksum:** 8-bit sum of the N program bytes, modulo 256. The length byte is excluded.
- **States** (`byte_ready` = 1 in OCIOSO, DADOS and CHECK; 0 in FEITO and ERRO):
  - OCIOSO: wait for the length byte, with no timeout.
    - Length byte = 0 → ERRO with `erro_checksum` = 1.
    - Otherwise latch N, clear the address counter and running sum, go to DADOS.
  - DADOS: on each transfer, register the address/data pair for a write, increment the address, and add the byte to the running sum.
    - After the transfer of byte N → CHECK.
  - CHECK: on transfer, compare `byte_in` with the running sum.
    - Equal → FEITO.
    - Not equal → ERRO with `erro_checksum` = 1.
  - FEITO: `carregado` = 1, `cpu_reset` = 0. Terminal state; only `reset` leaves it.
  - ERRO: `cpu_reset` stays 1, the error flag is held. Terminal state; only `reset` leaves it.
- **Idle counter:** active in DADOS and CHECK only.
  - Increments on every cycle without a transfer; clears on every transfer.
  - If a cycle without a transfer occurs while the counter equals `TIMEOUT`-1 → ERRO with `erro_timeout` = 1.
  - A transfer in that same cycle wins: no timeout.
- **Address width:** 8-bit. N ≤ 255 means the address never wraps.
- **Reset mid-operation:** all registers clear immediately and the state returns to OCIOSO. Memory contents already written are not erased. A new stream is required.
- **Bytes offered in FEITO or ERRO** are not accepted (`byte_ready` = 0) and are ignored.

## Timing
- **Reset values:**
  - state = OCIOSO, so `byte_ready` = 1 once reset deasserts (it is a decode of the state).
  - `mem_addr` = 0, `mem_dado` = 0, `mem_esc` = 0.
  - `cpu_reset` = 1, `carregado` = 0, `erro_checksum` = 0, `erro_timeout` = 0.
- **Memory write:** all memory outputs are registered. For a program byte accepted at edge k, `mem_addr`, `mem_dado` and `mem_esc` = 1 are valid during cycle k→k+1. `mem_esc` returns to 0 at edge k+1 unless another byte was accepted at k+1.
- **Throughput:** one byte per cycle. Back-to-back writes hold `mem_esc` high continuously with the address incrementing every cycle.
- **Successful load:** with the checksum accepted at edge k, `cpu_reset` falls to 0 and `carregado` rises to 1 at edge k (both registered). The last program write completes at edge k at the latest, so memory is complete before the processor leaves reset.
- **Error flags:** rise at the same edge the state enters ERRO.
- **Minimum load time:** N+2 accepted bytes, i.e. N+2 cycles with `byte_valid` held high.

## Test plan
- **Good load:** N=3, bytes 0x20, 0x41, 0x62, checksum 0xC3, `byte_valid` held high → writes (0,0x20), (1,0x41), (2,0x62) on consecutive cycles; at the checksum edge `cpu_reset`=0, `carregado`=1, `byte_ready`=0.
- **Bad checksum:** same stream with checksum 0x00 → three writes occur, then `erro_checksum`=1, `cpu_reset` stays 1, `byte_ready`=0; further bytes are ignored and no `mem_esc` pulses.
- **Zero length:** length byte 0x00 → ERRO with `erro_checksum`=1 at that edge; no `mem_esc` pulse ever.
- **Timeout** (`TIMEOUT`=8): length 0x02, one byte, then `byte_valid`=0 → `erro_timeout`=1 exactly 8 cycles after the last transfer. A repeat with a byte offered on the 8th idle cycle is accepted, with no timeout.
- **Gapped stream:** `byte_valid` toggled every other cycle, plus one 7-cycle gap (`TIMEOUT`=8); N=2, bytes 0xFF, 0x02, checksum 0x01 → loads successfully (the sum wraps mod 256), `carregado`=1.
- **Async reset:** assert `reset` mid-cycle after 2 of 4 bytes → outputs take their reset values without waiting for a clock edge; after release, a fresh good stream loads and `carregado`=1.

Source files
------------

// File: rtl/carregador_programa.sv
// carregador_programa: boot loader for the 8-bit nRISC processor.
// Receives a length-prefixed, checksummed program image as a byte stream,
// writes it into the instruction memory load port and releases the CPU
// from reset only after the complete image has been verified.
//
// Handshake: a byte is transferred on a rising edge of clock where both
// byte_valid and byte_ready are 1. The loader never waits on byte_valid
// to raise byte_ready; byte_ready is a pure decode of the current state.
module carregador_programa #(
   parameter int TIMEOUT = 1000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_dado,
   output logic       mem_esc,
   output logic       cpu_reset,
   output logic       carregado,
   output logic       erro_checksum,
   output logic       erro_timeout,
   output logic [2:0] estado_o
);

   // Idle counter only ever holds 0..TIMEOUT-1.
   localparam int IW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT - 1);
   localparam logic [IW-1:0] IDLE_ONE = IW'(1);

   typedef enum logic [2:0] {
      OCIOSO = 3'd0,
      DADOS  = 3'd1,
      CHECK  = 3'd2,
      FEITO  = 3'd3,
      ERRO   = 3'd4
   } estado_t;

   estado_t       state_q, state_d;
   logic [7:0]    len_q, len_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [7:0]    sum_q, sum_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [7:0]    mem_addr_q, mem_addr_d;
   logic [7:0]    mem_dado_q, mem_dado_d;
   logic          mem_esc_q, mem_esc_d;
   logic          erro_ck_q, erro_ck_d;
   logic          erro_to_q, erro_to_d;

   logic          xfer;
   logic          last_byte;
   logic          idle_expired;

   assign byte_ready   = (state_q == OCIOSO) || (state_q == DADOS) || (state_q == CHECK);
   assign xfer         = byte_valid && byte_ready;
   assign last_byte    = (cnt_q == (len_q - 8'd1));
   assign idle_expired = (idle_q == IDLE_LIM);

   // State and datapath registers; reset returns to an empty OCIOSO.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= OCIOSO;
         len_q      <= 8'd0;
         cnt_q      <= 8'd0;
         sum_q      <= 8'd0;
         idle_q     <= '0;
         mem_addr_q <= 8'd0;
         mem_dado_q <= 8'd0;
         mem_esc_q  <= 1'b0;
         erro_ck_q  <= 1'b0;
         erro_to_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         sum_q      <= sum_d;
         idle_q     <= idle_d;
         mem_addr_q <= mem_addr_d;
         mem_dado_q <= mem_dado_d;
         mem_esc_q  <= mem_esc_d;
         erro_ck_q  <= erro_ck_d;
         erro_to_q  <= erro_to_d;
      end
   end

   // Next-state and datapath updates for the stream parser.
   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      sum_d      = sum_q;
      idle_d     = idle_q;
      mem_addr_d = mem_addr_q;
      mem_dado_d = mem_dado_q;
      mem_esc_d  = 1'b0;
      erro_ck_d  = erro_ck_q;
      erro_to_d  = erro_to_q;

      case (state_q)
         OCIOSO: begin
            // No timeout here: the host may take as long as it likes to start.
            if (xfer) begin
               if (byte_in == 8'd0) begin
                  state_d   = ERRO;
                  erro_ck_d = 1'b1;
               end else begin
                  len_d   = byte_in;
                  cnt_d   = 8'd0;
                  sum_d   = 8'd0;
                  idle_d  = '0;
                  state_d = DADOS;
               end
            end
         end

         DADOS: begin
            if (xfer) begin
               mem_addr_d = cnt_q;
               mem_dado_d = byte_in;
               mem_esc_d  = 1'b1;
               cnt_d      = cnt_q + 8'd1;
               sum_d      = sum_q + byte_in;
               idle_d     = '0;
               if (last_byte) begin
                  state_d = CHECK;
               end
            end else if (idle_expired) begin
               state_d   = ERRO;
               erro_to_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end

         CHECK: begin
            if (xfer) begin
               idle_d = '0;
               if (byte_in == sum_q) begin
                  state_d = FEITO;
               end else begin
                  state_d   = ERRO;
                  erro_ck_d = 1'b1;
               end
            end else if (idle_expired) begin
               state_d   = ERRO;
               erro_to_d = 1'b1;
            end else begin
               idle_d = idle_q + IDLE_ONE;
            end
         end

         // FEITO and ERRO are terminal; only reset leaves them.
         default: begin
            state_d = state_q;
         end
      endcase
   end

   assign mem_addr      = mem_addr_q;
   assign mem_dado      = mem_dado_q;
   assign mem_esc       = mem_esc_q;
   // CPU stays in reset everywhere except after a verified load.
   assign cpu_reset     = (state_q != FEITO);
   assign carregado     = (state_q == FEITO);
   assign erro_checksum = erro_ck_q;
   assign erro_timeout  = erro_to_q;
   assign estado_o      = state_q;

endmodule

// File: tb/tb_carregador_programa.sv
// Testbench for carregador_programa: directed streams, scoreboard of
// expected memory writes checked by an independent monitor.
module tb_carregador_programa;

   logic       clock;
   logic       reset;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;
   logic [7:0] mem_addr;
   logic [7:0] mem_dado;
   logic       mem_esc;
   logic       cpu_reset;
   logic       carregado;
   logic       erro_checksum;
   logic       erro_timeout;
   logic [2:0] estado_o;

   int n_checks = 0;
   int n_fail   = 0;

   // expected writes: {addr, data}
   logic [15:0] exp_q[$];

   carregador_programa #(.TIMEOUT(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .byte_in       (byte_in),
      .byte_valid    (byte_valid),
      .byte_ready    (byte_ready),
      .mem_addr      (mem_addr),
      .mem_dado      (mem_dado),
      .mem_esc       (mem_esc),
      .cpu_reset     (cpu_reset),
      .carregado     (carregado),
      .erro_checksum (erro_checksum),
      .erro_timeout  (erro_timeout),
      .estado_o      (estado_o)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // driver tasks
   task automatic send_byte(input logic [7:0] b);
      byte_in    = b;
      byte_valid = 1'b1;
      @(posedge clock);
      #1;
   endtask

   task automatic send_data(input logic [7:0] addr, input logic [7:0] b);
      exp_q.push_back({addr, b});
      send_byte(b);
   endtask

   task automatic idle(input int n);
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic do_reset();
      byte_valid = 1'b0;
      reset      = 1'b1;
      #1;
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic check_drained(input string name);
      idle(2);
      check(name, 16'(exp_q.size()), 16'd0);
   endtask

   // scoreboard monitor: every write the DUT makes must match the queue head
   always @(negedge clock) begin
      if (!reset && mem_esc) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected at %0t",
                     mem_addr, mem_dado, $time);
         end else begin
            check("mem_write", {mem_addr, mem_dado}, exp_q.pop_front());
         end
      end
   end

   // stimulus
   initial begin
      reset      = 1'b1;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (2) @(posedge clock);
      #2;
      check("rst_mem_addr", 16'(mem_addr), 16'h00);
      check("rst_mem_dado", 16'(mem_dado), 16'h00);
      check("rst_mem_esc", 16'(mem_esc), 16'h0);
      check("rst_cpu_reset", 16'(cpu_reset), 16'h1);
      check("rst_carregado", 16'(carregado), 16'h0);
      check("rst_errs", {14'd0, erro_checksum, erro_timeout}, 16'h0);
      check("rst_byte_ready", 16'(byte_ready), 16'h1);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // good load
      send_byte(8'h03);
      check("good_cpu_reset_during", 16'(cpu_reset), 16'h1);
      send_data(8'd0, 8'h20);
      send_data(8'd1, 8'h41);
      send_data(8'd2, 8'h62);
      check("good_not_loaded_yet", 16'(carregado), 16'h0);
      send_byte(8'hC3);
      check("good_cpu_reset", 16'(cpu_reset), 16'h0);
      check("good_carregado", 16'(carregado), 16'h1);
      check("good_byte_ready", 16'(byte_ready), 16'h0);
      check("good_errs", {14'd0, erro_checksum, erro_timeout}, 16'h0);
      send_byte(8'h55);
      check_drained("good_writes_drained");

      // bad checksum
      do_reset();
      send_byte(8'h03);
      send_data(8'd0, 8'h20);
      send_data(8'd1, 8'h41);
      send_data(8'd2, 8'h62);
      send_byte(8'h00);
      check("badck_erro_checksum", 16'(erro_checksum), 16'h1);
      check("badck_cpu_reset", 16'(cpu_reset), 16'h1);
      check("badck_byte_ready", 16'(byte_ready), 16'h0);
      check("badck_carregado", 16'(carregado), 16'h0);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("badck_flag_held", 16'(erro_checksum), 16'h1);
      check("badck_no_timeout", 16'(erro_timeout), 16'h0);
      check_drained("badck_writes_drained");

      // zero length
      do_reset();
      send_byte(8'h00);
      check("zero_erro_checksum", 16'(erro_checksum), 16'h1);
      check("zero_byte_ready", 16'(byte_ready), 16'h0);
      check("zero_cpu_reset", 16'(cpu_reset), 16'h1);
      send_byte(8'h01);
      send_byte(8'h01);
      check_drained("zero_writes_drained");

      // timeout: error exactly 8 cycles after the last transfer
      do_reset();
      send_byte(8'h02);
      send_data(8'd0, 8'h11);
      byte_valid = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clock);
         #1;
         if (i == 7) begin
            check("to_not_yet", 16'(erro_timeout), 16'h0);
            check("to_ready_before", 16'(byte_ready), 16'h1);
         end
      end
      check("to_erro_timeout", 16'(erro_timeout), 16'h1);
      check("to_byte_ready", 16'(byte_ready), 16'h0);
      check("to_cpu_reset", 16'(cpu_reset), 16'h1);
      check("to_no_ck_err", 16'(erro_checksum), 16'h0);
      check_drained("to_writes_drained");

      // timeout boundary: a transfer on the 8th idle cycle wins
      do_reset();
      send_byte(8'h02);
      send_data(8'd0, 8'h11);
      idle(7);
      send_data(8'd1, 8'h22);
      check("tob_no_timeout", 16'(erro_timeout), 16'h0);
      send_byte(8'h33);
      check("tob_carregado", 16'(carregado), 16'h1);
      check_drained("tob_writes_drained");

      // gapped stream with sum wrap and a 7-cycle gap before the checksum
      do_reset();
      send_byte(8'h02);
      idle(1);
      send_data(8'd0, 8'hFF);
      idle(1);
      send_data(8'd1, 8'h02);
      idle(7);
      send_byte(8'h01);
      check("gap_carregado", 16'(carregado), 16'h1);
      check("gap_errs", {14'd0, erro_checksum, erro_timeout}, 16'h0);
      check_drained("gap_writes_drained");

      // asynchronous reset mid-load
      do_reset();
      send_byte(8'h04);
      send_data(8'd0, 8'h5A);
      send_data(8'd1, 8'hA5);
      byte_valid = 1'b0;
      reset      = 1'b1;
      #1;
      check("arst_mem_esc", 16'(mem_esc), 16'h0);
      check("arst_mem_addr", 16'(mem_addr), 16'h00);
      check("arst_mem_dado", 16'(mem_dado), 16'h00);
      check("arst_cpu_reset", 16'(cpu_reset), 16'h1);
      check("arst_byte_ready", 16'(byte_ready), 16'h1);
      exp_q.delete();
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      send_byte(8'h02);
      send_data(8'd0, 8'h10);
      send_data(8'd1, 8'h20);
      send_byte(8'h30);
      check("arst_reload_carregado", 16'(carregado), 16'h1);
      check("arst_reload_cpu_reset", 16'(cpu_reset), 16'h0);
      check_drained("arst_writes_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
